// File: rtl/mcbsp_pkg.sv
// Shared McBSP definitions: frame geometry, unpacker state encoding and word extraction.
// Used by both the receive capture side and the frame unpacker.
package mcbsp_pkg;

    localparam int WORDS_PER_FRAME = 8;
    localparam int BITS_PER_WORD   = 32;
    localparam int FRAME_BITS      = WORDS_PER_FRAME * BITS_PER_WORD;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Word 0 occupies the most significant bits of the frame.
    function automatic logic [BITS_PER_WORD-1:0] frame_word(
        input logic [FRAME_BITS-1:0] frame,
        input int                    idx
    );
        logic [FRAME_BITS-1:0] shifted;
        shifted = frame >> ((WORDS_PER_FRAME - 1 - idx) * BITS_PER_WORD);
        return shifted[BITS_PER_WORD-1:0];
    endfunction

endpackage

// File: rtl/mcbsp_frame_slot.sv
// One frame-wide holding register with an occupancy flag.
// Load wins over clear; only the flag is reset, the payload is don't-care while empty.
module mcbsp_frame_slot #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
        end else if (clear) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= din;
        end
    end

    assign dout  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/mcbsp_frame_unpacker.sv
// Replays received McBSP frames as an AXI-Stream of words, with one pending frame
// of buffering plus accepted-frame and dropped-frame accounting.
module mcbsp_frame_unpacker #(
    parameter int WORDS_PER_FRAME = 8,
    parameter int BITS_PER_WORD   = 32,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                     a_clk,
    input  logic                                     a_reset,
    input  logic [WORDS_PER_FRAME*BITS_PER_WORD-1:0] frame_data,
    input  logic                                     frame_valid,
    output logic [BITS_PER_WORD-1:0]                 M_AXIS_tdata,
    output logic                                     M_AXIS_tvalid,
    input  logic                                     M_AXIS_tready,
    output logic                                     M_AXIS_tlast,
    output logic                                     busy,
    output logic [CNT_WIDTH-1:0]                     frame_count,
    output logic [CNT_WIDTH-1:0]                     overrun_count
);

    import mcbsp_pkg::state_e;
    import mcbsp_pkg::IDLE;
    import mcbsp_pkg::STREAM;

    localparam int FB    = WORDS_PER_FRAME * BITS_PER_WORD;
    localparam int IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [CNT_WIDTH-1:0] ocnt_q, ocnt_d;

    logic          act_load, act_clear, act_valid;
    logic          pend_load, pend_clear, pend_valid;
    logic [FB-1:0] act_din, act_data, pend_data;
    logic [FB-1:0] act_shift;
    logic          tvalid, beat, last_beat;

    mcbsp_frame_slot #(.WIDTH(FB)) u_active (
        .clk   (a_clk),
        .rst   (a_reset),
        .load  (act_load),
        .clear (act_clear),
        .din   (act_din),
        .dout  (act_data),
        .valid (act_valid)
    );

    mcbsp_frame_slot #(.WIDTH(FB)) u_pending (
        .clk   (a_clk),
        .rst   (a_reset),
        .load  (pend_load),
        .clear (pend_clear),
        .din   (frame_data),
        .dout  (pend_data),
        .valid (pend_valid)
    );

    assign tvalid    = (state_q == STREAM);
    assign beat      = tvalid & M_AXIS_tready;
    assign last_beat = beat & (idx_q == LAST_IDX);

    // On a frame boundary ACTIVE refills from PENDING first, otherwise straight from the input.
    assign act_din = (last_beat && pend_valid) ? pend_data : frame_data;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        fcnt_d     = fcnt_q;
        ocnt_d     = ocnt_q;
        act_load   = 1'b0;
        act_clear  = 1'b0;
        pend_load  = 1'b0;
        pend_clear = 1'b0;

        if (state_q == IDLE) begin
            if (frame_valid) begin
                act_load = 1'b1;
                idx_d    = '0;
                fcnt_d   = fcnt_q + 1'b1;
                state_d  = STREAM;
            end
        end else if (last_beat) begin
            idx_d = '0;
            if (pend_valid) begin
                act_load = 1'b1;
                if (frame_valid) begin
                    pend_load = 1'b1;
                    fcnt_d    = fcnt_q + 1'b1;
                end else begin
                    pend_clear = 1'b1;
                end
            end else if (frame_valid) begin
                act_load = 1'b1;
                fcnt_d   = fcnt_q + 1'b1;
            end else begin
                act_clear = 1'b1;
                state_d   = IDLE;
            end
        end else begin
            if (beat) begin
                idx_d = idx_q + 1'b1;
            end
            if (frame_valid) begin
                if (!pend_valid) begin
                    pend_load = 1'b1;
                    fcnt_d    = fcnt_q + 1'b1;
                end else if (ocnt_q != '1) begin
                    ocnt_d = ocnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge a_clk) begin
        if (a_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            fcnt_q  <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            ocnt_q  <= ocnt_d;
        end
    end

    assign act_shift = act_data >> ((WORDS_PER_FRAME - 1 - int'(idx_q)) * BITS_PER_WORD);

    assign M_AXIS_tvalid = tvalid;
    assign M_AXIS_tdata  = tvalid ? act_shift[BITS_PER_WORD-1:0] : '0;
    assign M_AXIS_tlast  = tvalid & (idx_q == LAST_IDX);
    assign busy          = act_valid | pend_valid;
    assign frame_count   = fcnt_q;
    assign overrun_count = ocnt_q;

endmodule

// File: tb/tb_mcbsp_frame_unpacker.sv
// Randomised scoreboard bench for mcbsp_frame_unpacker, using a two-deep frame queue
// as the reference model and a narrowed counter width so wrap/saturation are reachable.
module tb_mcbsp_frame_unpacker;

    localparam int WPF   = 8;
    localparam int BPW   = 32;
    localparam int FB    = WPF * BPW;
    localparam int CW    = 10;
    localparam int CMAX  = (1 << CW) - 1;

    logic          a_clk = 1'b0;
    logic          a_reset;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic [BPW-1:0] M_AXIS_tdata;
    logic          M_AXIS_tvalid;
    logic          M_AXIS_tready;
    logic          M_AXIS_tlast;
    logic          busy;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] overrun_count;

    mcbsp_frame_unpacker #(
        .WORDS_PER_FRAME (WPF),
        .BITS_PER_WORD   (BPW),
        .CNT_WIDTH       (CW)
    ) dut (
        .a_clk         (a_clk),
        .a_reset       (a_reset),
        .frame_data    (frame_data),
        .frame_valid   (frame_valid),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tready (M_AXIS_tready),
        .M_AXIS_tlast  (M_AXIS_tlast),
        .busy          (busy),
        .frame_count   (frame_count),
        .overrun_count (overrun_count)
    );

    always #5 a_clk = ~a_clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;
    bit fc_wrapped = 1'b0;

    // Reference model: frames held in the block (at most two), words still owed per frame.
    int             held[$];
    logic [BPW-1:0] exp_data[$];
    bit             exp_last[$];
    int             m_fc = 0;
    int             m_oc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge a_clk) begin
        if (a_reset) begin
            held.delete();
            exp_data.delete();
            exp_last.delete();
            m_fc = 0;
            m_oc = 0;
        end else begin
            if (held.size() > 0 && M_AXIS_tready) begin
                held[0] = held[0] - 1;
                if (held[0] == 0) void'(held.pop_front());
            end
            if (frame_valid) begin
                if (held.size() < 2) begin
                    held.push_back(WPF);
                    for (int i = 0; i < WPF; i++) begin
                        exp_data.push_back(frame_data[FB-1-BPW*i -: BPW]);
                        exp_last.push_back(i == WPF - 1);
                    end
                    if (m_fc == CMAX) fc_wrapped = 1'b1;
                    m_fc = (m_fc + 1) & CMAX;
                end else if (m_oc < CMAX) begin
                    m_oc = m_oc + 1;
                end
            end
        end
    end

    // Monitor: compares the DUT against the model away from the active edge.
    logic [BPW-1:0] prev_data;
    bit             prev_stall = 1'b0;

    always @(negedge a_clk) begin
        if (chk_en) begin
            chk("tvalid", 64'(M_AXIS_tvalid), 64'(held.size() > 0));
            chk("busy", 64'(busy), 64'(held.size() > 0));
            chk("frame_count", 64'(frame_count), 64'(m_fc));
            chk("overrun_count", 64'(overrun_count), 64'(m_oc));
            if (prev_stall) chk("tdata_hold", 64'(M_AXIS_tdata), 64'(prev_data));
            if (M_AXIS_tvalid && M_AXIS_tready) begin
                if (exp_data.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL beat_unexpected: got %0h expected no beat at %0t", M_AXIS_tdata, $time);
                end else begin
                    chk("tdata", 64'(M_AXIS_tdata), 64'(exp_data.pop_front()));
                    chk("tlast", 64'(M_AXIS_tlast), 64'(exp_last.pop_front()));
                end
            end else if (!M_AXIS_tvalid) begin
                chk("idle_tdata", 64'(M_AXIS_tdata), 64'd0);
                chk("idle_tlast", 64'(M_AXIS_tlast), 64'd0);
            end
            prev_stall = M_AXIS_tvalid && !M_AXIS_tready;
            prev_data  = M_AXIS_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge a_clk);
        #1;
    endtask

    function automatic logic [FB-1:0] rand_frame();
        logic [FB-1:0] f;
        for (int i = 0; i < WPF; i++) f[BPW*i +: BPW] = $urandom;
        return f;
    endfunction

    logic [FB-1:0] seq_frame;

    initial begin
        a_reset       = 1'b1;
        frame_valid   = 1'b0;
        frame_data    = '0;
        M_AXIS_tready = 1'b0;
        step();
        step();
        chk_en  = 1'b1;
        step();
        a_reset = 1'b0;

        // Single frame 0x11111111..0x88888888, tready held high.
        for (int i = 0; i < WPF; i++) seq_frame[FB-1-BPW*i -: BPW] = {8{4'(i + 1)}};
        M_AXIS_tready = 1'b1;
        frame_data    = seq_frame;
        frame_valid   = 1'b1;
        step();
        frame_valid   = 1'b0;
        frame_data    = rand_frame();
        repeat (12) step();
        chk("single_frame_count", 64'(frame_count), 64'd1);

        // Backpressure pattern 1,0,0,1,...
        frame_data  = rand_frame();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            M_AXIS_tready = ((c % 3) == 0);
            step();
        end

        // Three frames two cycles apart under full backpressure: third is dropped.
        M_AXIS_tready = 1'b0;
        repeat (12) step();
        for (int k = 0; k < 3; k++) begin
            frame_data  = rand_frame();
            frame_valid = 1'b1;
            step();
            frame_valid = 1'b0;
            step();
        end
        chk("three_overrun", 64'(overrun_count), 64'd1);
        M_AXIS_tready = 1'b1;
        repeat (20) step();

        // New frame arrives in the same cycle as the last beat while PENDING is full.
        for (int c = 0; c < 30; c++) begin
            frame_valid = (c == 0) || (c == 1) || (c == 8);
            frame_data  = rand_frame();
            step();
        end
        frame_valid = 1'b0;
        chk("coincident_no_drop", 64'(overrun_count), 64'd1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            frame_valid   = ($urandom_range(0, 9) == 0);
            frame_data    = rand_frame();
            M_AXIS_tready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Drive drops past the counter limit.
        M_AXIS_tready = 1'b0;
        for (int c = 0; c < CMAX + 80; c++) begin
            frame_valid = 1'b1;
            frame_data  = rand_frame();
            step();
        end
        frame_valid = 1'b0;
        chk("overrun_saturated", 64'(overrun_count), 64'(CMAX));

        // Continuous offer with tready high: accepted frames wrap frame_count.
        M_AXIS_tready = 1'b1;
        for (int c = 0; c < 8 * (CMAX + 40); c++) begin
            frame_valid = 1'b1;
            frame_data  = rand_frame();
            step();
        end
        frame_valid = 1'b0;
        chk("frame_count_wrapped", 64'(fc_wrapped), 64'd1);
        repeat (20) step();

        // Reset mid-frame, then a fresh frame.
        frame_data  = rand_frame();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        repeat (4) step();
        a_reset = 1'b1;
        step();
        a_reset = 1'b0;
        chk("reset_tvalid", 64'(M_AXIS_tvalid), 64'd0);
        chk("reset_fcount", 64'(frame_count), 64'd0);
        repeat (3) step();
        frame_data  = rand_frame();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        repeat (15) step();

        chk("scoreboard_drained", 64'(exp_data.size()), 64'd0);
        chk("final_fcount", 64'(frame_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
